// File: rtl/mem_access_seq.sv
// mem_access_seq: splits 8/16-bit CPU load/store requests into little-endian
// byte accesses on main_memory's 8-bit port and returns the assembled result
// on a valid/ready response channel. One request in flight at a time.
module mem_access_seq #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic                req_size,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [2*DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_we,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic                  size_q, size_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_hi_q, wdata_hi_d;
  logic [2*DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic                  mem_we_q, mem_we_d;

  // The memory port is registered one state ahead: the edge entering LO/HI
  // loads the address/data/strobe for that state, so mem_* never sees req_*
  // combinationally and simply holds its last value in IDLE/RESP. The low
  // store byte goes straight into mem_wdata_q, so only the high byte is kept.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_hi_d  = wdata_hi_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d     = LO;
          we_d        = req_we;
          size_d      = req_size;
          addr_d      = req_addr;
          wdata_hi_d  = req_wdata[2*DATA_W-1:DATA_W];
          rdata_d     = '0;
          mem_addr_d  = req_addr;
          mem_wdata_d = req_wdata[DATA_W-1:0];
          mem_we_d    = req_we;
        end
      end
      LO: begin
        if (!we_q) rdata_d[DATA_W-1:0] = mem_rdata;
        if (size_q) begin
          state_d     = HI;
          mem_addr_d  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          mem_wdata_d = wdata_hi_q;
          mem_we_d    = we_q;
        end else begin
          state_d = RESP;
        end
      end
      HI: begin
        if (!we_q) rdata_d[2*DATA_W-1:DATA_W] = mem_rdata;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured request registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= 1'b0;
      addr_q      <= '0;
      wdata_hi_q  <= '0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      wdata_hi_q  <= wdata_hi_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;

endmodule

// File: tb/tb_mem_access_seq.sv
// Bench for mem_access_seq: directed requests against a byte-array memory
// model, expected responses queued at acceptance and checked on response.
module tb_mem_access_seq;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_size;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem [0:65535];
  logic [15:0] sb_q [$];

  int unsigned checks;
  int unsigned failures;

  mem_access_seq #(.ADDR_W(16), .DATA_W(8)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // main_memory model: combinational read, write on the rising edge
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One request with resp_ready held high. The acceptance edge is edge 1,
  // so a byte response is visible after edge 2 and a word after edge 3.
  task automatic run_req(input string tag, input logic we, input logic size,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] exp_rdata);
    int unsigned n;
    int unsigned we_cnt;
    int unsigned idx;
    logic [15:0] a_seq [2];
    logic [7:0]  d_seq [2];
    logic [15:0] exp;
    a_seq[0] = '0; a_seq[1] = '0; d_seq[0] = '0; d_seq[1] = '0;
    @(negedge clk);
    check({tag, "_req_ready_idle"}, 32'(req_ready), 32'd1);
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    sb_q.push_back(exp_rdata);
    n = 1; we_cnt = 0; idx = 0;
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = ~we;
    req_size  = ~size;
    req_addr  = ~addr;
    req_wdata = ~wdata;
    while (!resp_valid && n < 20) begin
      if (mem_we) we_cnt++;
      if (idx < 2) begin
        a_seq[idx] = mem_addr;
        d_seq[idx] = mem_wdata;
        idx++;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
    check({tag, "_latency"}, n, size ? 32'd3 : 32'd2);
    exp = sb_q.pop_front();
    check({tag, "_rdata"}, 32'(resp_rdata), 32'(exp));
    check({tag, "_we_cycles"}, we_cnt, we ? (size ? 32'd2 : 32'd1) : 32'd0);
    check({tag, "_addr_lo"}, 32'(a_seq[0]), 32'(addr));
    if (size) check({tag, "_addr_hi"}, 32'(a_seq[1]), 32'(16'(addr + 16'd1)));
    if (we) check({tag, "_wdata_lo"}, 32'(d_seq[0]), 32'(wdata[7:0]));
    if (we && size) check({tag, "_wdata_hi"}, 32'(d_seq[1]), 32'(wdata[15:8]));
    @(posedge clk);
    @(negedge clk);
    check({tag, "_resp_done"}, 32'(resp_valid), 32'd0);
    check({tag, "_req_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] bp_exp;
    int unsigned n;
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b1;

    // reset state
    #12;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", 32'(resp_rdata), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // byte store, word store, word load back
    run_req("bst_0010", 1'b1, 1'b0, 16'h0010, 16'h12A5, 16'h0000);
    check("mem_0010", 32'(mem[16'h0010]), 32'h00A5);
    run_req("wst_0100", 1'b1, 1'b1, 16'h0100, 16'hBEEF, 16'h0000);
    check("mem_0100", 32'(mem[16'h0100]), 32'h00EF);
    check("mem_0101", 32'(mem[16'h0101]), 32'h00BE);
    run_req("wld_0100", 1'b0, 1'b1, 16'h0100, 16'h0000, 16'hBEEF);

    // address wrap on the high byte
    run_req("bst_ffff", 1'b1, 1'b0, 16'hFFFF, 16'h0034, 16'h0000);
    run_req("bst_0000", 1'b1, 1'b0, 16'h0000, 16'h0012, 16'h0000);
    run_req("wld_ffff", 1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h1234);

    // byte load is zero-extended
    run_req("bld_0101", 1'b0, 1'b0, 16'h0101, 16'hFFFF, 16'h00BE);

    // backpressure: 5 cycles of resp_ready=0 with a competing request
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_size   = 1'b1;
    req_addr   = 16'h0100;
    req_wdata  = 16'h0000;
    @(posedge clk);
    sb_q.push_back(16'hBEEF);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("bp_resp_valid", 32'(resp_valid), 32'd1);
    bp_exp    = sb_q.pop_front();
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 1'b0;
    req_addr  = 16'h0300;
    req_wdata = 16'h00C3;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_hold_valid", 32'(resp_valid), 32'd1);
      check("bp_hold_rdata", 32'(resp_rdata), 32'(bp_exp));
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_mem_we", 32'(mem_we), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("bp_handshake", 32'(resp_valid), 32'd0);
    check("bp_req_ready_back", 32'(req_ready), 32'd1);
    check("bp_no_store", 32'(mem[16'h0300] === 8'hC3), 32'd0);

    // reset during HI of a word store
    run_req("bst_0201", 1'b1, 1'b0, 16'h0201, 16'h0077, 16'h0000);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 1'b1;
    req_addr  = 16'h0200;
    req_wdata = 16'h5566;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rm_lo_we", 32'(mem_we), 32'd1);
    check("rm_lo_addr", 32'(mem_addr), 32'h0200);
    @(posedge clk);
    @(negedge clk);
    check("rm_hi_we", 32'(mem_we), 32'd1);
    check("rm_hi_addr", 32'(mem_addr), 32'h0201);
    #2;
    rst_n = 1'b0;
    #1;
    check("rm_async_we", 32'(mem_we), 32'd0);
    check("rm_resp_valid", 32'(resp_valid), 32'd0);
    check("rm_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    check("rm_mem_0200", 32'(mem[16'h0200]), 32'h0066);
    check("rm_mem_0201", 32'(mem[16'h0201]), 32'h0077);
    run_req("bld_0200", 1'b0, 1'b0, 16'h0200, 16'h0000, 16'h0066);
    run_req("bld_0201", 1'b0, 1'b0, 16'h0201, 16'h0000, 16'h0077);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
